writeback_pipe: RTL and testbench
=================================

WRITEBACK_PIPE -- requirements
Module: writeback_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 7, number of result stages per lane; stage DEPTH is the writeback output register.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports even_valid_input / odd_valid_input  input  1  result present from the even/odd execution unit this cycle.
REQ-005 SHALL have ports even_latency_input / odd_latency_input  input  [0:2]  remaining cycles until writeback, legal range 1..DEPTH.
REQ-006 SHALL have ports even_rt_address_input / odd_rt_address_input  input  [0:6]  destination register, 0..127.
REQ-007 SHALL have ports even_rt_input / odd_rt_input  input  [0:127]  result value.
REQ-008 SHALL have ports stall_input  input  1  hold all stages; flush_input  input  1  discard uncommitted results.
REQ-009 SHALL have ports rt_address_even_output / rt_address_odd_output  output  [0:6]  writeback address to the register file.
REQ-010 SHALL have ports rt_even_output / rt_odd_output  output  [0:127]  writeback data.
REQ-011 SHALL have ports register_write_even_output / register_write_odd_output  output  1  writeback enable.
REQ-012 SHALL have ports collision_error_output  output  1  sticky error; pending_count_output  output  [0:3]  valid entries in both lanes, 0..14.

Function
REQ-013 Each lane SHALL hold DEPTH entries {valid, address, data}; without stall or flush, entry at stage s moves to stage s+1 each cycle; stage DEPTH entry is retired (overwritten by stage DEPTH-1).
REQ-014 An insert with latency L at cycle t SHALL be written into stage DEPTH-L+1, so its write-enable is high exactly in cycle t+L (L=1: next cycle).
REQ-015 Outputs SHALL be driven directly from stage DEPTH registers; register_write_*_output = stage DEPTH valid and not stall_input.
REQ-016 If an insert targets a stage that simultaneously receives a valid shifted entry, the insert SHALL overwrite it and collision_error_output SHALL set.
REQ-017 Insert with L=0 or L>DEPTH SHALL be dropped and set collision_error_output.
REQ-018 While stall_input=1, all stages SHALL hold, register_write outputs SHALL be 0, and any insert SHALL be dropped and set collision_error_output; the held stage DEPTH entry writes in the first cycle after stall releases.
REQ-019 flush_input=1 SHALL clear valid in stages 1..DEPTH-1 of both lanes and drop same-cycle inserts; the current stage DEPTH entry still writes this cycle; flush has priority over stall.
REQ-020 If both lanes present valid writebacks with equal addresses in the same cycle, register_write_even_output SHALL be forced 0 (odd wins) and collision_error_output SHALL set.
REQ-021 pending_count_output SHALL be registered and equal the valid-entry count of both lanes after the same edge's update.
REQ-022 collision_error_output SHALL clear only on reset.

Reset
REQ-023 With reset=1 at a posedge, all valid bits, addresses, data, outputs, pending_count_output and collision_error_output SHALL become 0; reset overrides stall, flush and inserts.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight entries with no writeback in the following cycle.

Structure
REQ-025 Package spu_pkg SHALL hold WB_DEPTH (=7), width constants (ADDR_W=7, DATA_W=128) and typedef wb_entry_t {valid, address, data}.
REQ-026 One sub-module writeback_lane (shift stages, insert, stall, flush, per-lane count and collision) SHALL be instantiated twice; the top holds cross-lane address conflict, count sum and sticky error.

Verification
REQ-027 Even insert L=3, addr 5, data 0xA5..A5 at cycle 10 -> register_write_even_output=1, addr 5, data 0xA5..A5 only in cycle 13.
REQ-028 Even insert L=4 at cycle 10 and L=2 at cycle 12 -> collision at stage 6 in cycle 12, second entry written cycle 14, collision_error_output=1, first entry never written.
REQ-029 Odd insert L=5 at cycle 0, stall cycles 2-3 -> odd writeback in cycle 7, register_write_odd_output=0 during stall.
REQ-030 Inserts L=1 and L=4 at cycle 0, flush cycle 1 -> L=1 entry written cycle 1, L=4 entry never written, pending_count_output=0 after cycle 1.
REQ-031 Even and odd both L=2, addr 9, cycle 0 -> cycle 2 only odd write asserted, collision_error_output=1.
REQ-032 Fill all 14 stages, assert reset -> next cycle all outputs 0, pending_count_output=0, no write-enables.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared constants and the writeback entry type for the SPU result pipeline.
package spu_pkg;

   localparam int WB_DEPTH = 7;
   localparam int ADDR_W   = 7;
   localparam int DATA_W   = 128;
   localparam int LAT_W    = 3;
   localparam int CNT_W    = 4;

   typedef struct packed {
      logic              valid;
      logic [0:ADDR_W-1] address;
      logic [0:DATA_W-1] data;
   } wb_entry_t;

   // A latency is usable only if it lands inside the pipeline (1..depth).
   function automatic logic latency_legal(input logic [0:LAT_W-1] latency, input int depth);
      return (latency != '0) && (int'(latency) <= depth);
   endfunction

endpackage

// File: rtl/writeback_lane.sv
// One result lane: a DEPTH-stage shift register whose last stage is the
// writeback register, with latency-addressed insertion, stall and flush.
module writeback_lane
   import spu_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              insert_valid,
   input  logic [0:LAT_W-1]  insert_latency,
   input  logic [0:ADDR_W-1] insert_address,
   input  logic [0:DATA_W-1] insert_data,
   output wb_entry_t         head,
   output logic [0:CNT_W-1]  count_next,
   output logic              collision
);

   wb_entry_t        stage_reg  [1:DEPTH];
   wb_entry_t        stage_next [1:DEPTH];
   wb_entry_t        shift_in   [1:DEPTH];
   wb_entry_t        insert_entry;
   logic [DEPTH:1]   hit;
   logic [DEPTH:1]   overwrite;
   logic             latency_ok;
   logic             insert_ok;

   assign latency_ok   = latency_legal(insert_latency, DEPTH);
   assign insert_ok    = insert_valid && latency_ok && !stall && !flush;
   assign insert_entry = {1'b1, insert_address, insert_data};

   // Entry arriving at each stage from its predecessor; stage 1 has none.
   always_comb begin
      shift_in[1] = '0;
      for (int i = 2; i <= DEPTH; i++) begin
         shift_in[i] = stage_reg[i-1];
      end
   end

   // Latency L targets stage DEPTH-L+1 so it reaches the head after L edges.
   generate
      for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_target
         assign hit[gi]       = insert_ok && (int'(insert_latency) == DEPTH - gi + 1);
         assign overwrite[gi] = hit[gi] && shift_in[gi].valid;
      end
   endgenerate

   always_comb begin
      for (int i = 1; i <= DEPTH; i++) begin
         stage_next[i] = stage_reg[i];
         if (flush) begin
            if (!stall) begin
               stage_next[i] = shift_in[i];
            end
            // A stalled head has not written yet, so it survives the flush.
            if (i != DEPTH || !stall) begin
               stage_next[i].valid = 1'b0;
            end
         end else if (!stall) begin
            stage_next[i] = hit[i] ? insert_entry : shift_in[i];
         end
      end
   end

   always_comb begin
      count_next = '0;
      for (int i = 1; i <= DEPTH; i++) begin
         count_next = count_next + CNT_W'(stage_next[i].valid);
      end
   end

   assign collision = (|overwrite) || (insert_valid && !flush && (stall || !latency_ok));
   assign head      = stage_reg[DEPTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 1; i <= DEPTH; i++) begin
            stage_reg[i] <= '0;
         end
      end else begin
         for (int i = 1; i <= DEPTH; i++) begin
            stage_reg[i] <= stage_next[i];
         end
      end
   end

endmodule

// File: rtl/writeback_pipe.sv
// Dual-lane (even/odd) writeback pipeline: two result lanes, cross-lane
// address arbitration, occupancy count and a sticky collision flag.
module writeback_pipe
   import spu_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              even_valid_input,
   input  logic              odd_valid_input,
   input  logic [0:2]        even_latency_input,
   input  logic [0:2]        odd_latency_input,
   input  logic [0:6]        even_rt_address_input,
   input  logic [0:6]        odd_rt_address_input,
   input  logic [0:127]      even_rt_input,
   input  logic [0:127]      odd_rt_input,
   input  logic              stall_input,
   input  logic              flush_input,
   output logic [0:6]        rt_address_even_output,
   output logic [0:6]        rt_address_odd_output,
   output logic [0:127]      rt_even_output,
   output logic [0:127]      rt_odd_output,
   output logic              register_write_even_output,
   output logic              register_write_odd_output,
   output logic              collision_error_output,
   output logic [0:3]        pending_count_output
);

   logic              lane_valid     [2];
   logic [0:LAT_W-1]  lane_latency   [2];
   logic [0:ADDR_W-1] lane_address   [2];
   logic [0:DATA_W-1] lane_data      [2];
   wb_entry_t         lane_head      [2];
   logic [0:CNT_W-1]  lane_count_next[2];
   logic              lane_collision [2];

   logic              even_write;
   logic              odd_write;
   logic              address_conflict;
   logic [0:CNT_W-1]  pending_reg;
   logic              error_reg;

   // Index 0 is the even lane, index 1 the odd lane.
   assign lane_valid[0]   = even_valid_input;
   assign lane_valid[1]   = odd_valid_input;
   assign lane_latency[0] = even_latency_input;
   assign lane_latency[1] = odd_latency_input;
   assign lane_address[0] = even_rt_address_input;
   assign lane_address[1] = odd_rt_address_input;
   assign lane_data[0]    = even_rt_input;
   assign lane_data[1]    = odd_rt_input;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         writeback_lane #(
            .DEPTH          (DEPTH)
         ) u_lane (
            .clock          (clock),
            .reset          (reset),
            .stall          (stall_input),
            .flush          (flush_input),
            .insert_valid   (lane_valid[gi]),
            .insert_latency (lane_latency[gi]),
            .insert_address (lane_address[gi]),
            .insert_data    (lane_data[gi]),
            .head           (lane_head[gi]),
            .count_next     (lane_count_next[gi]),
            .collision      (lane_collision[gi])
         );
      end
   endgenerate

   assign even_write       = lane_head[0].valid && !stall_input;
   assign odd_write        = lane_head[1].valid && !stall_input;
   // Same-register writes in one cycle: the odd lane is the younger result and wins.
   assign address_conflict = even_write && odd_write &&
                             (lane_head[0].address == lane_head[1].address);

   assign register_write_even_output = even_write && !address_conflict;
   assign register_write_odd_output  = odd_write;
   assign rt_address_even_output     = lane_head[0].address;
   assign rt_address_odd_output      = lane_head[1].address;
   assign rt_even_output             = lane_head[0].data;
   assign rt_odd_output              = lane_head[1].data;
   assign pending_count_output       = pending_reg;
   assign collision_error_output     = error_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         pending_reg <= '0;
         error_reg   <= 1'b0;
      end else begin
         pending_reg <= lane_count_next[0] + lane_count_next[1];
         error_reg   <= error_reg | lane_collision[0] | lane_collision[1] | address_conflict;
      end
   end

endmodule

// File: tb/tb_writeback_pipe.sv
// Self-checking bench for writeback_pipe: latency table, directed corner
// sequences and a random run against an in-flight-list reference model.
module tb_writeback_pipe;

   localparam int DEPTH = 7;

   logic          clock = 1'b0;
   logic          reset;
   logic          even_valid_input, odd_valid_input;
   logic [0:2]    even_latency_input, odd_latency_input;
   logic [0:6]    even_rt_address_input, odd_rt_address_input;
   logic [0:127]  even_rt_input, odd_rt_input;
   logic          stall_input, flush_input;
   logic [0:6]    rt_address_even_output, rt_address_odd_output;
   logic [0:127]  rt_even_output, rt_odd_output;
   logic          register_write_even_output, register_write_odd_output;
   logic          collision_error_output;
   logic [0:3]    pending_count_output;

   always #5 clock = ~clock;

   writeback_pipe #(.DEPTH(DEPTH)) dut (
      .clock                      (clock),
      .reset                      (reset),
      .even_valid_input           (even_valid_input),
      .odd_valid_input            (odd_valid_input),
      .even_latency_input         (even_latency_input),
      .odd_latency_input          (odd_latency_input),
      .even_rt_address_input      (even_rt_address_input),
      .odd_rt_address_input       (odd_rt_address_input),
      .even_rt_input              (even_rt_input),
      .odd_rt_input               (odd_rt_input),
      .stall_input                (stall_input),
      .flush_input                (flush_input),
      .rt_address_even_output     (rt_address_even_output),
      .rt_address_odd_output      (rt_address_odd_output),
      .rt_even_output             (rt_even_output),
      .rt_odd_output              (rt_odd_output),
      .register_write_even_output (register_write_even_output),
      .register_write_odd_output  (register_write_odd_output),
      .collision_error_output     (collision_error_output),
      .pending_count_output       (pending_count_output)
   );

   // Reference model: list of in-flight results, each counting down to writeback.
   typedef struct {
      int           lane;
      int           due;
      logic [6:0]   addr;
      logic [127:0] data;
   } ment_t;

   ment_t mq[$];
   bit    m_err;
   int    m_pend;

   int n_cmp = 0;
   int n_bad = 0;
   int seq_cyc = 0;

   bit           h_we_e[64], h_we_o[64], h_err[64];
   logic [6:0]   h_addr_e[64], h_addr_o[64];
   logic [127:0] h_data_e[64], h_data_o[64];
   int           h_pend[64];

   typedef struct {
      int           lane;
      int           lat;
      logic [6:0]   addr;
      logic [127:0] data;
      int           exp_cyc;
      bit           exp_err;
   } vec_t;

   vec_t tbl[10];

   function automatic int find(input int lane, input int due);
      foreach (mq[i]) begin
         if (mq[i].lane == lane && mq[i].due == due) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s seq_cyc=%0d actual=%0h required=%0h", name, seq_cyc, act, exp);
      end
   endtask

   task automatic check_outputs();
      int he, ho;
      bit ewe_e, ewe_o;
      he = find(0, 0);
      ho = find(1, 0);
      ewe_o = (ho >= 0) && !stall_input;
      ewe_e = (he >= 0) && !stall_input;
      if (ewe_e && ewe_o && mq[he].addr == mq[ho].addr) ewe_e = 1'b0;
      chk("we_even", register_write_even_output, ewe_e);
      chk("we_odd", register_write_odd_output, ewe_o);
      if (he >= 0) chk("wb_even", {rt_address_even_output, rt_even_output}, {mq[he].addr, mq[he].data});
      if (ho >= 0) chk("wb_odd", {rt_address_odd_output, rt_odd_output}, {mq[ho].addr, mq[ho].data});
      chk("pending", pending_count_output, m_pend);
      chk("error", collision_error_output, m_err);
      if (seq_cyc < 64) begin
         h_we_e[seq_cyc]   = register_write_even_output;
         h_we_o[seq_cyc]   = register_write_odd_output;
         h_addr_e[seq_cyc] = rt_address_even_output;
         h_addr_o[seq_cyc] = rt_address_odd_output;
         h_data_e[seq_cyc] = rt_even_output;
         h_data_o[seq_cyc] = rt_odd_output;
         h_pend[seq_cyc]   = pending_count_output;
         h_err[seq_cyc]    = collision_error_output;
      end
   endtask

   task automatic lane_insert(input int lane, input bit v, input int lat,
                              input logic [6:0] a, input logic [127:0] d);
      int k;
      if (!v) return;
      if (lat < 1 || lat > DEPTH) begin
         m_err = 1'b1;
         return;
      end
      k = find(lane, lat - 1);
      if (k >= 0) begin
         mq.delete(k);
         m_err = 1'b1;
      end
      mq.push_back('{lane: lane, due: lat - 1, addr: a, data: d});
   endtask

   task automatic model_update();
      int he, ho;
      if (reset) begin
         mq.delete();
         m_err  = 1'b0;
         m_pend = 0;
         return;
      end
      he = find(0, 0);
      ho = find(1, 0);
      if (!stall_input && he >= 0 && ho >= 0 && mq[he].addr == mq[ho].addr) m_err = 1'b1;
      if (flush_input) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!stall_input || mq[i].due != 0) mq.delete(i);
         end
      end else if (stall_input) begin
         if (even_valid_input || odd_valid_input) m_err = 1'b1;
      end else begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].due == 0) mq.delete(i);
            else mq[i].due = mq[i].due - 1;
         end
         lane_insert(0, even_valid_input, int'(even_latency_input), even_rt_address_input, even_rt_input);
         lane_insert(1, odd_valid_input, int'(odd_latency_input), odd_rt_address_input, odd_rt_input);
      end
      m_pend = mq.size();
   endtask

   task automatic cycle();
      #1;
      check_outputs();
      @(posedge clock);
      model_update();
      @(negedge clock);
      seq_cyc++;
   endtask

   task automatic idle();
      reset = 1'b0;
      stall_input = 1'b0;
      flush_input = 1'b0;
      even_valid_input = 1'b0;
      odd_valid_input = 1'b0;
      even_latency_input = '0;
      odd_latency_input = '0;
      even_rt_address_input = '0;
      odd_rt_address_input = '0;
      even_rt_input = '0;
      odd_rt_input = '0;
   endtask

   task automatic set_ins(input int lane, input int lat, input logic [6:0] a, input logic [127:0] d);
      if (lane == 0) begin
         even_valid_input = 1'b1;
         even_latency_input = 3'(lat);
         even_rt_address_input = a;
         even_rt_input = d;
      end else begin
         odd_valid_input = 1'b1;
         odd_latency_input = 3'(lat);
         odd_rt_address_input = a;
         odd_rt_input = d;
      end
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      cycle();
      idle();
      seq_cyc = 0;
   endtask

   function automatic int first_we(input int lane, input int n);
      for (int c = 0; c < n; c++) begin
         if ((lane == 0) ? h_we_e[c] : h_we_o[c]) return c;
      end
      return -1;
   endfunction

   function automatic int count_we(input int lane, input int n);
      int cnt = 0;
      for (int c = 0; c < n; c++) begin
         if ((lane == 0) ? h_we_e[c] : h_we_o[c]) cnt++;
      end
      return cnt;
   endfunction

   initial begin
      logic [127:0] pat_a5, pat_x, pat_y;
      int fc;
      pat_a5 = {16{8'hA5}};
      pat_x  = {4{32'h1111_2222}};
      pat_y  = {4{32'h3333_4444}};

      tbl[0] = '{lane: 0, lat: 3, addr: 7'd5,   data: pat_a5, exp_cyc: 3,  exp_err: 1'b0};
      tbl[1] = '{lane: 0, lat: 1, addr: 7'h11,  data: pat_x,  exp_cyc: 1,  exp_err: 1'b0};
      tbl[2] = '{lane: 0, lat: 7, addr: 7'h7f,  data: pat_y,  exp_cyc: 7,  exp_err: 1'b0};
      tbl[3] = '{lane: 1, lat: 1, addr: 7'd0,   data: pat_a5, exp_cyc: 1,  exp_err: 1'b0};
      tbl[4] = '{lane: 1, lat: 5, addr: 7'h2a,  data: pat_x,  exp_cyc: 5,  exp_err: 1'b0};
      tbl[5] = '{lane: 1, lat: 7, addr: 7'h40,  data: pat_y,  exp_cyc: 7,  exp_err: 1'b0};
      tbl[6] = '{lane: 0, lat: 0, addr: 7'd3,   data: pat_x,  exp_cyc: -1, exp_err: 1'b1};
      tbl[7] = '{lane: 1, lat: 0, addr: 7'd4,   data: pat_y,  exp_cyc: -1, exp_err: 1'b1};
      tbl[8] = '{lane: 0, lat: 2, addr: 7'h55,  data: pat_y,  exp_cyc: 2,  exp_err: 1'b0};
      tbl[9] = '{lane: 1, lat: 6, addr: 7'h66,  data: pat_a5, exp_cyc: 6,  exp_err: 1'b0};

      // Power-up reset: DUT state is unknown beforehand, so only check afterwards.
      idle();
      reset = 1'b1;
      @(negedge clock);
      @(posedge clock);
      model_update();
      @(negedge clock);
      idle();
      #1;
      chk("rst_we", {register_write_even_output, register_write_odd_output}, 2'b00);
      chk("rst_addr", {rt_address_even_output, rt_address_odd_output}, 14'h0);
      chk("rst_data", {rt_even_output, rt_odd_output}, 256'h0);
      chk("rst_pending", pending_count_output, 4'd0);
      chk("rst_error", collision_error_output, 1'b0);

      // Table: single insert per lane, writeback cycle and data.
      for (int r = 0; r < 10; r++) begin
         do_reset();
         set_ins(tbl[r].lane, tbl[r].lat, tbl[r].addr, tbl[r].data);
         cycle();
         for (int c = 1; c < 10; c++) begin
            idle();
            cycle();
         end
         fc = first_we(tbl[r].lane, 10);
         chk("tbl_cycle", fc, tbl[r].exp_cyc);
         chk("tbl_count", count_we(tbl[r].lane, 10), (tbl[r].exp_cyc >= 0) ? 1 : 0);
         if (fc >= 0) begin
            if (tbl[r].lane == 0) chk("tbl_wb", {h_addr_e[fc], h_data_e[fc]}, {tbl[r].addr, tbl[r].data});
            else chk("tbl_wb", {h_addr_o[fc], h_data_o[fc]}, {tbl[r].addr, tbl[r].data});
         end
         chk("tbl_err", h_err[9], tbl[r].exp_err);
      end

      // Overwrite collision: L=4 at 10 replaced by L=2 at 12.
      do_reset();
      for (int c = 0; c < 17; c++) begin
         idle();
         if (c == 10) set_ins(0, 4, 7'd1, pat_x);
         if (c == 12) set_ins(0, 2, 7'd2, pat_y);
         cycle();
      end
      chk("ovw_cycle", first_we(0, 17), 14);
      chk("ovw_count", count_we(0, 17), 1);
      chk("ovw_wb", {h_addr_e[14], h_data_e[14]}, {7'd2, pat_y});
      chk("ovw_err_pre", h_err[12], 1'b0);
      chk("ovw_err_post", h_err[13], 1'b1);

      // Stall holds an odd result for two cycles.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         idle();
         if (c == 0) set_ins(1, 5, 7'd8, pat_a5);
         if (c == 2 || c == 3) stall_input = 1'b1;
         cycle();
      end
      chk("stall_cycle", first_we(1, 10), 7);
      chk("stall_count", count_we(1, 10), 1);
      chk("stall_err", h_err[9], 1'b0);

      // Flush: head still writes, younger entry is discarded.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         idle();
         if (c == 0) begin
            set_ins(0, 1, 7'd3, pat_x);
            set_ins(1, 4, 7'd4, pat_y);
         end
         if (c == 1) flush_input = 1'b1;
         cycle();
      end
      chk("flush_head", h_we_e[1], 1'b1);
      chk("flush_lost", count_we(1, 8), 0);
      chk("flush_pend_pre", h_pend[1], 2);
      chk("flush_pend_post", h_pend[2], 0);

      // Same destination on both lanes: odd wins.
      do_reset();
      for (int c = 0; c < 5; c++) begin
         idle();
         if (c == 0) begin
            set_ins(0, 2, 7'd9, pat_x);
            set_ins(1, 2, 7'd9, pat_y);
         end
         cycle();
      end
      chk("xlane_odd", h_we_o[2], 1'b1);
      chk("xlane_even", h_we_e[2], 1'b0);
      chk("xlane_err_pre", h_err[2], 1'b0);
      chk("xlane_err_post", h_err[3], 1'b1);

      // Fill all stages, then reset mid-flight.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         idle();
         if (c < DEPTH) begin
            set_ins(0, DEPTH, 7'(c), pat_x ^ 128'(c));
            set_ins(1, DEPTH, 7'(64 + c), pat_y ^ 128'(c));
         end
         if (c == 7) reset = 1'b1;
         cycle();
      end
      chk("fill_pend", h_pend[7], 14);
      chk("fill_rst_we", {h_we_e[8], h_we_o[8]}, 2'b00);
      chk("fill_rst_pend", h_pend[8], 0);
      chk("fill_rst_out", {h_addr_e[8], h_addr_o[8], h_data_e[8], h_data_o[8]}, 270'h0);
      chk("fill_rst_err", h_err[8], 1'b0);

      // Random traffic against the reference model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         idle();
         reset       = ($urandom_range(0, 199) == 0);
         stall_input = ($urandom_range(0, 99) < 10);
         flush_input = ($urandom_range(0, 99) < 5);
         if ($urandom_range(0, 1) == 1)
            set_ins(0, $urandom_range(0, 7), 7'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
         if ($urandom_range(0, 1) == 1)
            set_ins(1, $urandom_range(0, 7), 7'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
